inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 118 +++++++++++
 tb/tb_inst_fetch.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch front end: issues one word-aligned read at a time, buffers the
// returned instruction for decode, and follows execute-stage redirects.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic [31:0] inst,
  output logic [31:0] pc_addr,
  output logic        inst_valid,
  input  logic        id_ready,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_STALLED} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_addr_q, pc_addr_d;
  logic        inst_valid_q, inst_valid_d;
  logic        kill_q, kill_d;
  logic [31:0] redir_pc;
  logic        transfer;

  assign redir_pc = redirect_addr & ~32'h3;
  assign transfer = inst_valid_q && id_ready;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    inst_d       = inst_q;
    pc_addr_d    = pc_addr_q;
    inst_valid_d = inst_valid_q;
    kill_d       = kill_q;
    unique case (state_q)
      S_REQ: begin
        if (redirect_valid) fetch_pc_d = redir_pc;
        if (mem_req_ready) begin
          // A request accepted alongside a redirect fetches a stale address.
          kill_d  = redirect_valid;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          fetch_pc_d = redir_pc;
          kill_d     = 1'b1;
        end
        if (mem_resp_valid) begin
          kill_d = 1'b0;
          if (kill_q || redirect_valid) begin
            state_d = S_REQ;
          end else begin
            inst_d       = mem_resp_data;
            pc_addr_d    = fetch_pc_q;
            inst_valid_d = 1'b1;
            fetch_pc_d   = fetch_pc_q + 32'd4;
            state_d      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid || transfer) begin
          inst_valid_d = 1'b0;
          inst_d       = NOP_INST;
        end
        if (redirect_valid) begin
          fetch_pc_d = redir_pc;
          state_d    = S_REQ;
        end else if (transfer) begin
          state_d = stall ? S_STALLED : S_REQ;
        end
      end
      S_STALLED: begin
        if (redirect_valid) begin
          fetch_pc_d = redir_pc;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_REQ;
      fetch_pc_q   <= RESET_PC;
      inst_q       <= NOP_INST;
      pc_addr_q    <= RESET_PC;
      inst_valid_q <= 1'b0;
      kill_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      inst_q       <= inst_d;
      pc_addr_q    <= pc_addr_d;
      inst_valid_q <= inst_valid_d;
      kill_q       <= kill_d;
    end
  end

  // Gated by rst_n so the request drops the instant reset asserts.
  assign mem_req_valid = rst_n && (state_q == S_REQ);
  assign mem_req_addr  = fetch_pc_q;
  assign inst          = inst_q;
  assign pc_addr       = pc_addr_q;
  assign inst_valid    = inst_valid_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: table-driven fetch vectors, hand-written redirect/reset
// sequences, and a scoreboard of instructions expected at the decode handoff.
module tb_inst_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req_valid, mem_req_ready, mem_resp_valid;
  logic [31:0] mem_req_addr, mem_resp_data;
  logic [31:0] inst, pc_addr, redirect_addr;
  logic        inst_valid, id_ready, stall, redirect_valid;

  logic        w_req_valid, w_inst_valid;
  logic [31:0] w_req_addr, w_inst, w_pc_addr;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [31:0] exp_addr;
    logic [31:0] data;
    logic        stall;
    int          hold;
    logic [31:0] target;
  } vec_t;
  vec_t vecs[4];

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .inst(inst), .pc_addr(pc_addr),
    .inst_valid(inst_valid), .id_ready(id_ready), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .mem_req_valid(w_req_valid), .mem_req_addr(w_req_addr),
    .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .inst(w_inst), .pc_addr(w_pc_addr),
    .inst_valid(w_inst_valid), .id_ready(id_ready), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every decode handoff must match the oldest expected instruction.
  always @(negedge clk) begin
    if (rst_n && inst_valid && id_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got pc 0x%08h inst 0x%08h expected no transfer", pc_addr, inst);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("sb_pc", pc_addr, e.pc);
        check("sb_inst", inst, e.inst);
      end
    end
  end

  task automatic fetch_one(input vec_t v, input bit wrap_chk);
    check("req_valid", {31'd0, mem_req_valid}, 32'd1);
    check("req_addr", mem_req_addr, v.exp_addr);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    check("wait_noreq", {31'd0, mem_req_valid}, 32'd0);
    check("wait_invalid", {31'd0, inst_valid}, 32'd0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = v.data;
    sb.push_back({v.exp_addr, v.data});
    step();
    mem_resp_valid = 1'b0;
    check("hold_valid", {31'd0, inst_valid}, 32'd1);
    if (wrap_chk) check("wrap_pc_addr", w_pc_addr, 32'hFFFF_FFFC);
    for (int k = 0; k < v.hold; k++) begin
      // Stray responses while holding must not disturb the buffer.
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'hBAD0_0000 + k;
      check("hold_noreq", {31'd0, mem_req_valid}, 32'd0);
      check("hold_inst", inst, v.data);
      check("hold_pc", pc_addr, v.exp_addr);
      step();
    end
    mem_resp_valid = 1'b0;
    id_ready = 1'b1;
    stall    = v.stall;
    step();
    id_ready = 1'b0;
    stall    = 1'b0;
    check("post_xfer_valid", {31'd0, inst_valid}, 32'd0);
    check("post_xfer_nop", inst, NOP);
    if (wrap_chk) check("wrap_second_addr", w_req_addr, 32'h0000_0000);
    if (v.stall) begin
      for (int k = 0; k < 10; k++) begin
        check("stalled_noreq", {31'd0, mem_req_valid}, 32'd0);
        step();
      end
      redirect_valid = 1'b1;
      redirect_addr  = v.target;
      step();
      redirect_valid = 1'b0;
    end
  endtask

  initial begin
    vecs[0] = '{32'h0000_0000, 32'h0050_0093, 1'b0, 0, 32'h0};
    vecs[1] = '{32'h0000_0004, 32'h0010_0113, 1'b0, 5, 32'h0};
    vecs[2] = '{32'h0000_0008, 32'h0080_006F, 1'b1, 0, 32'h0000_0100};
    vecs[3] = '{32'h0000_0100, 32'h0000_0513, 1'b0, 2, 32'h0};

    rst_n = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
    id_ready = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_addr = 32'h0;
    step();
    step();
    check("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst", inst, NOP);
    check("rst_pc_addr", pc_addr, 32'h0);
    rst_n = 1'b1;
    #1;
    check("wrap_first_addr", w_req_addr, 32'hFFFF_FFFC);

    for (int i = 0; i < 4; i++) fetch_one(vecs[i], i == 0);

    // Redirect in REQ without ready; low address bits are dropped.
    redirect_valid = 1'b1; redirect_addr = 32'h0000_0407;
    step();
    redirect_valid = 1'b0;
    check("redir_req_addr", mem_req_addr, 32'h0000_0404);
    check("redir_req_valid", {31'd0, mem_req_valid}, 32'd1);

    // Redirect during WAIT, response on the following cycle is discarded.
    mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_addr = 32'h0000_0200; step(); redirect_valid = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_BEEF; step(); mem_resp_valid = 1'b0;
    check("wait_redir_valid", {31'd0, inst_valid}, 32'd0);
    check("wait_redir_addr", mem_req_addr, 32'h0000_0200);
    check("wait_redir_req", {31'd0, mem_req_valid}, 32'd1);

    // Redirect in the same cycle the request is accepted.
    mem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_addr = 32'h0000_0300;
    step();
    mem_req_ready = 1'b0; redirect_valid = 1'b0;
    check("acc_redir_wait", {31'd0, mem_req_valid}, 32'd0);
    mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_BEEF; step(); mem_resp_valid = 1'b0;
    check("acc_redir_valid", {31'd0, inst_valid}, 32'd0);
    check("acc_redir_addr", mem_req_addr, 32'h0000_0300);

    // Redirect in the response cycle itself.
    mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'hCAFE_F00D;
    redirect_valid = 1'b1; redirect_addr = 32'h0000_0500;
    step();
    mem_resp_valid = 1'b0; redirect_valid = 1'b0;
    check("resp_redir_valid", {31'd0, inst_valid}, 32'd0);
    check("resp_redir_inst", inst, NOP);
    check("resp_redir_addr", mem_req_addr, 32'h0000_0500);

    // Redirect while holding an unconsumed instruction drops it.
    mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h1111_1111; step(); mem_resp_valid = 1'b0;
    check("hold2_valid", {31'd0, inst_valid}, 32'd1);
    check("hold2_pc", pc_addr, 32'h0000_0500);
    redirect_valid = 1'b1; redirect_addr = 32'h0000_0600; step(); redirect_valid = 1'b0;
    check("hold_redir_valid", {31'd0, inst_valid}, 32'd0);
    check("hold_redir_inst", inst, NOP);
    check("hold_redir_addr", mem_req_addr, 32'h0000_0600);
    check("hold_redir_req", {31'd0, mem_req_valid}, 32'd1);

    // Redirect beats stall; the same-cycle transfer is still consumed.
    mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h2222_2222;
    sb.push_back({32'h0000_0600, 32'h2222_2222});
    step();
    mem_resp_valid = 1'b0;
    id_ready = 1'b1; stall = 1'b1; redirect_valid = 1'b1; redirect_addr = 32'h0000_0700;
    step();
    id_ready = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    check("prio_valid", {31'd0, inst_valid}, 32'd0);
    check("prio_req", {31'd0, mem_req_valid}, 32'd1);
    check("prio_addr", mem_req_addr, 32'h0000_0700);

    // Reset pulse while a request is outstanding.
    mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst2_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("rst2_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst2_inst", inst, NOP);
    check("rst2_pc_addr", pc_addr, 32'h0);
    step();
    rst_n = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_data = 32'hBAD_BAD00;
    #1;
    check("rst2_first_req", {31'd0, mem_req_valid}, 32'd1);
    check("rst2_first_addr", mem_req_addr, 32'h0);
    step();
    mem_resp_valid = 1'b0;
    check("late_resp_valid", {31'd0, inst_valid}, 32'd0);
    check("late_resp_addr", mem_req_addr, 32'h0);
    fetch_one('{32'h0000_0000, 32'h0000_0093, 1'b0, 1, 32'h0}, 1'b0);

    check("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
